bsg_counter_clear_up_down_one_hot: RTL and testbench
====================================================

# bsg_counter_clear_up_down_one_hot

Parametrised one-hot counter. The count is held as a single set bit in a register of max_val_p+1 bits. It supports synchronous clear, increment, decrement, a selectable wrap or saturate mode, and a registered binary mirror of the count. It is the general successor to the clear/up-only one-hot counter and is used for round-robin pointers, credit and occupancy tracking, and FIFO slot selection. In those uses the one-hot form feeds muxes directly and the binary form feeds status logic.

## Interface
- max_val_p, 32, largest count value; the one-hot vector is max_val_p+1 bits wide (must be >= 1)
- init_val_p, 0, value loaded by reset and by clear_i (0 <= init_val_p <= max_val_p)
- saturate_p, 0, 0 = wrap at the ends; 1 = hold at 0 and max_val_p
- lg_els_lp (localparam), $clog2(max_val_p+1), binary count width (minimum 1)

Ports:
- clk_i  input  1  clock, rising edge
- reset_i  input  1  asynchronous, active-high reset
- clear_i  input  1  synchronous return to init_val_p
- up_i  input  1  increment request
- down_i  input  1  decrement request
- count_r_o  output  max_val_p+1  one-hot count; bit k set means count == k
- count_bin_r_o  output  lg_els_lp  binary encoding of count_r_o, registered
- at_max_o  output  1  combinational, count_r_o[max_val_p]
- at_zero_o  output  1  combinational, count_r_o[0]
- wrap_r_o  output  1  registered one-cycle pulse: the previous edge wrapped (wrap mode only)

## Operation
- Base value: B = one-hot(init_val_p) if clear_i is high, else the current count_r_o.
- Net step: up_i & ~down_i gives +1; down_i & ~up_i gives -1; both or neither gives 0.
- Step of +1:
  - wrap mode: rotate B left by one; bit max_val_p moves to bit 0.
  - saturate mode: if B[max_val_p] is set, hold; else shift left.
- Step of -1:
  - wrap mode: rotate B right; bit 0 moves to bit max_val_p.
  - saturate mode: if B[0] is set, hold; else shift right.
- clear_i with a step: the step applies to the cleared value. For example, clear_i & up_i gives init_val_p+1, modulo or saturated per mode.
- The register loads only when clear_i | up_i | down_i is high, which saves power. Otherwise it holds.
- count_bin_r_o is updated on the same edge as count_r_o with the binary form of the next value. It is a separate register, not a decode of count_r_o after the edge.
- wrap_r_o is set on the edge where the count moves from max_val_p to 0 or from 0 to max_val_p through rotation. It clears on the next edge that is not a wrap. wrap_r_o is tied to 0 when saturate_p=1.
- Invariant: exactly one bit of count_r_o is set at all times after reset. No input sequence may break it.
- max_val_p=1 degenerate case: a 2-bit vector; up and down both toggle the count in wrap mode.

## Timing
- Reset: async assert takes effect with no clock. While reset_i is high:
  - count_r_o = one-hot(init_val_p)
  - count_bin_r_o = init_val_p
  - wrap_r_o = 0
  - at_zero_o/at_max_o reflect init_val_p
- Reset deassertion is synchronised externally. The first edge with reset_i low may step the count.
- Latency: input to count_r_o, count_bin_r_o and wrap_r_o is 1 cycle. at_max_o/at_zero_o have 0 cycles of latency from the register.
- Reset asserted mid-operation: the count returns to init immediately, regardless of clear_i/up_i/down_i.
- No handshake. All of clear_i, up_i and down_i are sampled every edge.

## Test plan
- max_val_p=4, init=0, wrap: reset; up_i for 6 cycles. Required:
  - count_r_o = 00001 → 00010 → 00100 → 01000 → 10000 → 00001 → 00010
  - count_bin_r_o = 0,1,2,3,4,0,1
  - wrap_r_o high only in the cycle after 10000 → 00001
- Same configuration, count 0, down_i for one cycle. Required: count_r_o = 10000, count_bin_r_o = 4, wrap_r_o = 1, at_max_o = 1.
- max_val_p=4, saturate_p=1:
  - from 0, up_i for 7 cycles: count holds at 10000, at_max_o = 1, wrap_r_o never set.
  - then down_i for 7 cycles: count holds at 00001.
- init_val_p=2, count at 3:
  - clear_i alone gives 00100.
  - clear_i & up_i gives 01000.
  - clear_i & down_i gives 00010.
  - up_i & down_i together gives no change.
- Async reset at count 3, asserted between clock edges. Required: count_r_o = 00100 (init=2) and count_bin_r_o = 2 before the next edge; the value holds while reset_i is high.
- Random clear/up/down for 10k cycles, checked against a reference model, with assertions:
  - $onehot(count_r_o) every cycle
  - count_bin_r_o matches the encoding of count_r_o

Source files
------------

// File: rtl/bsg_counter_clear_up_down_one_hot.sv
// One-hot up/down counter with synchronous clear, wrap or saturate mode,
// a registered binary mirror of the count and a registered wrap pulse.
module bsg_counter_clear_up_down_one_hot
#(
    parameter int max_val_p  = 32,
    parameter int init_val_p = 0,
    parameter int saturate_p = 0,
    localparam int lg_els_lp = (max_val_p < 1) ? 1 : $clog2(max_val_p + 1)
)
(
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 clear_i,
    input  logic                 up_i,
    input  logic                 down_i,
    output logic [max_val_p:0]   count_r_o,
    output logic [lg_els_lp-1:0] count_bin_r_o,
    output logic                 at_max_o,
    output logic                 at_zero_o,
    output logic                 wrap_r_o
);

    localparam bit                 wrap_mode_lp = (saturate_p == 0);
    localparam logic [max_val_p:0] init_oh_lp   = {{max_val_p{1'b0}}, 1'b1} << init_val_p;
    localparam logic [lg_els_lp-1:0] init_bin_lp = lg_els_lp'(init_val_p);
    localparam logic [lg_els_lp-1:0] max_bin_lp  = lg_els_lp'(max_val_p);

    // One-hot step: rotate in wrap mode, shift-with-hold in saturate mode.
    function automatic logic [max_val_p:0] step_oh(input logic [max_val_p:0] b,
                                                   input logic inc, input logic dec);
        logic [max_val_p:0] r;
        r = b;
        if (inc) begin
            if (!wrap_mode_lp) r = b[max_val_p] ? b : (b << 1);
            else               r = {b[max_val_p-1:0], b[max_val_p]};
        end else if (dec) begin
            if (!wrap_mode_lp) r = b[0] ? b : (b >> 1);
            else               r = {b[0], b[max_val_p:1]};
        end
        return r;
    endfunction

    // Binary step kept arithmetically so the mirror is never a decode.
    function automatic logic [lg_els_lp-1:0] step_bin(input logic [lg_els_lp-1:0] b,
                                                      input logic inc, input logic dec);
        logic [lg_els_lp-1:0] r;
        r = b;
        if (inc) begin
            if (b == max_bin_lp) r = wrap_mode_lp ? '0 : b;
            else                 r = b + lg_els_lp'(1);
        end else if (dec) begin
            if (b == '0)         r = wrap_mode_lp ? max_bin_lp : b;
            else                 r = b - lg_els_lp'(1);
        end
        return r;
    endfunction

    logic                 inc;
    logic                 dec;
    logic                 load;
    logic [max_val_p:0]   base_oh;
    logic [lg_els_lp-1:0] base_bin;
    logic [max_val_p:0]   next_oh;
    logic [lg_els_lp-1:0] next_bin;
    logic                 next_wrap;

    // Next-value selection: clear picks the base, then the net step applies.
    always_comb begin
        inc       = up_i & ~down_i;
        dec       = down_i & ~up_i;
        load      = clear_i | up_i | down_i;
        base_oh   = clear_i ? init_oh_lp  : count_r_o;
        base_bin  = clear_i ? init_bin_lp : count_bin_r_o;
        next_oh   = step_oh(base_oh, inc, dec);
        next_bin  = step_bin(base_bin, inc, dec);
        next_wrap = wrap_mode_lp & ((inc & base_oh[max_val_p]) | (dec & base_oh[0]));
    end

    // Count registers load only when some request is active.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_r_o     <= init_oh_lp;
            count_bin_r_o <= init_bin_lp;
        end else if (load) begin
            count_r_o     <= next_oh;
            count_bin_r_o <= next_bin;
        end
    end

    // Wrap pulse updates every edge so it lasts exactly one cycle.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) wrap_r_o <= 1'b0;
        else         wrap_r_o <= next_wrap;
    end

    assign at_max_o  = count_r_o[max_val_p];
    assign at_zero_o = count_r_o[0];

endmodule

// File: tb/tb_bsg_counter_clear_up_down_one_hot.sv
// Bench for the one-hot up/down counter: four configurations driven by the
// same inputs, each compared every cycle against an integer count model.
module tb_bsg_counter_clear_up_down_one_hot;

    localparam int N = 4;
    // instance 0: max4 init0 wrap; 1: max4 init0 sat; 2: max4 init2 wrap; 3: max1 init0 wrap
    localparam int MAXV [N] = '{4, 4, 4, 1};
    localparam int INIT [N] = '{0, 0, 2, 0};
    localparam int SAT  [N] = '{0, 1, 0, 0};

    logic clk = 1'b0, rst = 1'b0, clr = 1'b0, up = 1'b0, dn = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] oh0, oh1, oh2;
    logic [1:0] oh3;
    logic [2:0] bn0, bn1, bn2;
    logic [0:0] bn3;
    logic [N-1:0] amax, azero, wr;

    bsg_counter_clear_up_down_one_hot #(.max_val_p(4), .init_val_p(0), .saturate_p(0)) u_wrap (
        .clk_i(clk), .reset_i(rst), .clear_i(clr), .up_i(up), .down_i(dn),
        .count_r_o(oh0), .count_bin_r_o(bn0), .at_max_o(amax[0]), .at_zero_o(azero[0]), .wrap_r_o(wr[0]));
    bsg_counter_clear_up_down_one_hot #(.max_val_p(4), .init_val_p(0), .saturate_p(1)) u_sat (
        .clk_i(clk), .reset_i(rst), .clear_i(clr), .up_i(up), .down_i(dn),
        .count_r_o(oh1), .count_bin_r_o(bn1), .at_max_o(amax[1]), .at_zero_o(azero[1]), .wrap_r_o(wr[1]));
    bsg_counter_clear_up_down_one_hot #(.max_val_p(4), .init_val_p(2), .saturate_p(0)) u_init (
        .clk_i(clk), .reset_i(rst), .clear_i(clr), .up_i(up), .down_i(dn),
        .count_r_o(oh2), .count_bin_r_o(bn2), .at_max_o(amax[2]), .at_zero_o(azero[2]), .wrap_r_o(wr[2]));
    bsg_counter_clear_up_down_one_hot #(.max_val_p(1), .init_val_p(0), .saturate_p(0)) u_one (
        .clk_i(clk), .reset_i(rst), .clear_i(clr), .up_i(up), .down_i(dn),
        .count_r_o(oh3), .count_bin_r_o(bn3), .at_max_o(amax[3]), .at_zero_o(azero[3]), .wrap_r_o(wr[3]));

    logic [63:0] dut_oh [N];
    logic [63:0] dut_bin [N];
    assign dut_oh[0] = 64'(oh0);  assign dut_bin[0] = 64'(bn0);
    assign dut_oh[1] = 64'(oh1);  assign dut_bin[1] = 64'(bn1);
    assign dut_oh[2] = 64'(oh2);  assign dut_bin[2] = 64'(bn2);
    assign dut_oh[3] = 64'(oh3);  assign dut_bin[3] = 64'(bn3);

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    // Reference: the count as a plain integer.
    int m_cnt [N];
    bit m_wrap [N];

    function automatic int step_of(bit u, bit d);
        if (u && !d) return 1;
        if (d && !u) return -1;
        return 0;
    endfunction

    function automatic int model_next(int c, bit cl, bit u, bit d, int mx, int ini, int sat);
        int b, n;
        b = cl ? ini : c;
        n = b + step_of(u, d);
        if (sat != 0) begin
            if (n > mx) n = mx;
            if (n < 0)  n = 0;
        end else begin
            n = (n + mx + 1) % (mx + 1);
        end
        return n;
    endfunction

    function automatic bit model_wrap(int c, bit cl, bit u, bit d, int mx, int ini, int sat);
        int b, s;
        if (sat != 0) return 1'b0;
        b = cl ? ini : c;
        s = step_of(u, d);
        return (s == 1 && b == mx) || (s == -1 && b == 0);
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                m_cnt[i]  <= INIT[i];
                m_wrap[i] <= 1'b0;
            end else begin
                m_cnt[i]  <= model_next(m_cnt[i], clr, up, dn, MAXV[i], INIT[i], SAT[i]);
                m_wrap[i] <= model_wrap(m_cnt[i], clr, up, dn, MAXV[i], INIT[i], SAT[i]);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < N; i++) begin
                int enc;
                enc = 0;
                for (int k = 0; k < 64; k++) if (dut_oh[i][k]) enc = k;
                chk($sformatf("onehot[%0d]", i), 64'($onehot(dut_oh[i])), 64'd1);
                chk($sformatf("bin_enc[%0d]", i), dut_bin[i], 64'(enc));
                chk($sformatf("count[%0d]", i), dut_oh[i], 64'd1 << m_cnt[i]);
                chk($sformatf("bin[%0d]", i), dut_bin[i], 64'(m_cnt[i]));
                chk($sformatf("wrap[%0d]", i), 64'(wr[i]), 64'(m_wrap[i]));
                chk($sformatf("at_max[%0d]", i), 64'(amax[i]), 64'(m_cnt[i] == MAXV[i]));
                chk($sformatf("at_zero[%0d]", i), 64'(azero[i]), 64'(m_cnt[i] == 0));
            end
        end
    end

    task automatic step(input bit c, input bit u, input bit d);
        clr = c; up = u; dn = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [4:0] exp_oh [6] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001, 5'b00010};
    int         exp_bn [6] = '{1, 2, 3, 4, 0, 1};
    bit         exp_wr [6] = '{0, 0, 0, 0, 1, 0};

    initial begin
        #2 rst = 1'b1;
        #1 cmp_en = 1'b1;
        chk("rst_wrap_oh", 64'(oh0), 64'b00001);
        chk("rst_init_oh", 64'(oh2), 64'b00100);
        chk("rst_init_bin", 64'(bn2), 64'd2);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // up for six cycles through a wrap
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 1'b0);
            chk("up_seq_oh", 64'(oh0), 64'(exp_oh[i]));
            chk("up_seq_bin", 64'(bn0), 64'(exp_bn[i]));
            chk("up_seq_wrap", 64'(wr[0]), 64'(exp_wr[i]));
        end

        // down from zero wraps to max
        step(1'b1, 1'b0, 1'b0);
        chk("clear_to_zero", 64'(oh0), 64'b00001);
        step(1'b0, 1'b0, 1'b1);
        chk("down_wrap_oh", 64'(oh0), 64'b10000);
        chk("down_wrap_bin", 64'(bn0), 64'd4);
        chk("down_wrap_pulse", 64'(wr[0]), 64'd1);
        chk("down_wrap_atmax", 64'(amax[0]), 64'd1);

        // clear combinations on init=2 instance
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("init_at3", 64'(oh2), 64'b01000);
        step(1'b1, 1'b0, 1'b0);
        chk("clear_alone", 64'(oh2), 64'b00100);
        step(1'b1, 1'b1, 1'b0);
        chk("clear_up", 64'(oh2), 64'b01000);
        step(1'b1, 1'b0, 1'b1);
        chk("clear_down", 64'(oh2), 64'b00010);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        chk("up_down_hold", 64'(oh2), 64'b01000);

        // saturation at both ends
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, 1'b0);
            chk("sat_no_wrap", 64'(wr[1]), 64'd0);
        end
        chk("sat_hi_oh", 64'(oh1), 64'b10000);
        chk("sat_hi_atmax", 64'(amax[1]), 64'd1);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1);
        chk("sat_lo_oh", 64'(oh1), 64'b00001);
        chk("sat_lo_atzero", 64'(azero[1]), 64'd1);

        // async reset between edges, with requests still active
        step(1'b1, 1'b1, 1'b0);
        chk("pre_reset_at3", 64'(oh2), 64'b01000);
        clr = 1'b0; up = 1'b1; dn = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_oh", 64'(oh2), 64'b00100);
        chk("async_rst_bin", 64'(bn2), 64'd2);
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold_oh", 64'(oh2), 64'b00100);
        rst = 1'b0; up = 1'b0;

        // randomized traffic with occasional resets
        for (int i = 0; i < 10000; i++) begin
            rst = ($urandom_range(0, 999) == 0);
            clr = ($urandom_range(0, 15) == 0);
            up  = 1'($urandom);
            dn  = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
